alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised successor to the d16 single-cycle ALU; sits in the execute stage between register read and writeback/memory.
- Keeps all existing single-cycle operations (add/sub/adc/sbb/cmp, logic, shifts), with flags generalised to WIDTH bits.
- Adds real ROL/RCL and an iterative shift-add multiplier and restoring divider.
- A valid/ready handshake lets the pipeline stall on multi-cycle operations.

Parameters:
- WIDTH, 16, datapath width in bits (min 8, max 64).
- SHAMT_W, 4, shift-amount bits used from operand b (log2 WIDTH).
- CNT_W, 5, iteration counter width (log2 WIDTH + 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- alu_control  in  8  opcode, OPC_* values from cpu_constants.vh (incl. OPC_MUL, OPC_DIV, OPC_MOD).
- op_a  in  WIDTH  rD operand.
- op_b  in  WIDTH  rS or immediate, already muxed upstream.
- flags_in  in  4  current flags, FLAG_BIT_* positions.
- out_valid  out  1  one-cycle pulse: result/flags valid.
- out  out  WIDTH  primary result.
- out_hi  out  WIDTH  MUL high half / DIV remainder; 0 otherwise.
- write  out  1  result is written to rD.
- flags_out  out  4  flags for this result.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset (async, rst_n=0) clears all outputs and internal state:
  - out, out_hi, flags_out are 0; out_valid, write, busy are 0; in_ready is 1; state goes to IDLE.
  - Reset mid-operation abandons the op and produces no out_valid.
- A request is accepted when in_valid & in_ready. in_ready = (state==IDLE), so it is combinational from state only.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + single-cycle opcode → stays IDLE. Results register on the accept edge; out_valid=1 the next cycle (latency 1).
  - IDLE + OPC_MUL → MUL.
  - IDLE + OPC_DIV or OPC_MOD with op_b≠0 → DIV.
  - IDLE + OPC_DIV or OPC_MOD with op_b==0 → single-cycle divide-by-zero response (see Divide below).
  - MUL/DIV: counter loads WIDTH and decrements each cycle; at counter==1 → DONE.
  - DONE: registers the result, pulses out_valid, then → IDLE. Total latency for MUL/DIV is WIDTH+1 cycles.
- busy = state is MUL or DIV or DONE. in_valid is ignored while busy and must be held by upstream.
- Arithmetic is internally WIDTH+1 bits.
  - Carry = bit WIDTH of the result; Z = (out==0); S = out[WIDTH-1].
  - V is set only for ADD/ADC/CMP/SUB/SBB, using the sign rule: operands have equal effective signs (b inverted for subtract) and the result sign differs.
  - Logic ops and MOV: C=0, V=0.
- Shifts:
  - Only op_b[SHAMT_W-1:0] is used.
  - SHL: C = last bit shifted out.
  - SHR: logical, C=0.
  - ROL: rotate left, C = new bit 0.
  - RCL: rotate through carry (WIDTH+1 bit ring with flags_in carry).
  - Amount 0: out = op_a, C = flags_in carry.
- Multiply: unsigned, 2·WIDTH-bit product.
  - out = low half, out_hi = high half.
  - C = V = (out_hi≠0); Z and S taken from out.
- Divide: unsigned restoring, one quotient bit per cycle.
  - OPC_DIV: out = quotient, out_hi = remainder.
  - OPC_MOD: out = remainder, out_hi = quotient.
  - op_b==0: no iteration. Quotient = all ones, remainder = op_a, V=1, out_valid the next cycle.
- write = 0 for OPC_CMP, OPC_ST, OPC_JMP, OPC_PUSH; 1 otherwise. Registered with the result.
- Unknown opcode: out = 0, flags Z=1 and others 0, write=1, latency 1.
- out, out_hi, flags_out and write hold their values between out_valid pulses.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: MUL/DIV/MOD are implemented as above, along with the MUL, DIV and DONE states.
- Undefined:
  - OPC_MUL, OPC_DIV and OPC_MOD decode as unknown opcodes (out=0, Z=1, latency 1).
  - The FSM is reduced to IDLE only; busy is tied to 0 and in_ready to 1.
  - The multiplier, divider and counter logic is not synthesised.

Test Plan (WIDTH=16):
- ADD a=0x7FFF, b=0x0001 → 1 cycle later: out_valid=1, out=0x8000, S=1, V=1, C=0, Z=0.
- SUB a=0x0000, b=0x0001 → out=0xFFFF, C=1, V=0, write=1. The same operands with CMP → write=0, same flags.
- RCL a=0x8001, b=1, flags_in C=0 → out=0x0002, C=1. ROL with the same inputs → out=0x0003, C=1.
- MUL a=0xFFFF, b=0xFFFF:
  - busy=1 and in_ready=0 for 17 cycles; a second in_valid during that time is ignored.
  - out_valid pulses at cycle 17 with out=0x0001, out_hi=0xFFFE, C=V=1.
- DIV a=100, b=7 → out=14, out_hi=2 after 17 cycles. DIV b=0 → 1 cycle: out=0xFFFF, out_hi=100, V=1.
- MUL started, rst_n=0 at cycle 5 → all outputs 0 immediately, in_ready=1, no out_valid afterwards. A following ADD 1+1 yields out=2.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the execute-stage pipeline and alu_seq.
//
// Handshake: a request transfers on a rising clk edge where in_valid and in_ready
// are both high. in_ready depends on the ALU state only, never on in_valid. While
// busy, in_valid is ignored and upstream keeps the request stable. out_valid is a
// single-cycle pulse with no back-pressure; out/out_hi/flags_out/write keep their
// last values between pulses.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       alu_control;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       flags_in;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             write;
    logic [3:0]       flags_out;
    logic             busy;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output in_valid, alu_control, op_a, op_b, flags_in,
        input  in_ready, out_valid, out, out_hi, write, flags_out, busy
    );

    // ALU side.
    modport slave (
        input  in_valid, alu_control, op_a, op_b, flags_in,
        output in_ready, out_valid, out, out_hi, write, flags_out, busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: parametrised execute-stage ALU with single-cycle arithmetic/logic/shift
// ops plus an iterative shift-add multiplier and restoring divider.
// Optional feature macro: ALU_MULDIV_EN (MUL/DIV/MOD and the MUL/DIV/DONE states).
// Without it those opcodes decode as unknown and the ALU is always ready.

// Opcode and flag encodings, matching cpu_constants.vh.
package alu_seq_pkg;
    localparam logic [7:0] OPC_ADD  = 8'h00;
    localparam logic [7:0] OPC_SUB  = 8'h01;
    localparam logic [7:0] OPC_ADC  = 8'h02;
    localparam logic [7:0] OPC_SBB  = 8'h03;
    localparam logic [7:0] OPC_CMP  = 8'h04;
    localparam logic [7:0] OPC_AND  = 8'h05;
    localparam logic [7:0] OPC_OR   = 8'h06;
    localparam logic [7:0] OPC_XOR  = 8'h07;
    localparam logic [7:0] OPC_NOT  = 8'h08;
    localparam logic [7:0] OPC_MOV  = 8'h09;
    localparam logic [7:0] OPC_SHL  = 8'h0A;
    localparam logic [7:0] OPC_SHR  = 8'h0B;
    localparam logic [7:0] OPC_ROL  = 8'h0C;
    localparam logic [7:0] OPC_RCL  = 8'h0D;
    localparam logic [7:0] OPC_MUL  = 8'h0E;
    localparam logic [7:0] OPC_DIV  = 8'h0F;
    localparam logic [7:0] OPC_MOD  = 8'h10;
    localparam logic [7:0] OPC_ST   = 8'h11;
    localparam logic [7:0] OPC_JMP  = 8'h12;
    localparam logic [7:0] OPC_PUSH = 8'h13;

    localparam int FLAG_BIT_C = 0;
    localparam int FLAG_BIT_Z = 1;
    localparam int FLAG_BIT_S = 2;
    localparam int FLAG_BIT_V = 3;
endpackage

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e state;

    logic               accept;
    logic               start_mul;
    logic               start_div;
    logic               start_multi;

    logic [WIDTH-1:0]   sc_out;
    logic [WIDTH-1:0]   sc_hi;
    logic               sc_c;
    logic               sc_v;
    logic               sc_wr;
    logic [3:0]         sc_flags;
    logic [WIDTH:0]     arith;
    logic [WIDTH:0]     ring;
    logic [WIDTH:0]     ring_rot;
    logic [SHAMT_W-1:0] amt;
    logic [CNT_W-1:0]   rol_back;
    logic [CNT_W-1:0]   rcl_back;
    logic               cin;

    assign accept      = bus.in_valid & bus.in_ready;
    assign start_multi = start_mul | start_div;
    assign cin         = bus.flags_in[FLAG_BIT_C];
    assign amt         = bus.op_b[SHAMT_W-1:0];
    assign rol_back    = CNT_W'(WIDTH) - CNT_W'(amt);
    assign rcl_back    = CNT_W'(WIDTH + 1) - CNT_W'(amt);
    assign ring        = {cin, bus.op_a};
    assign ring_rot    = (ring << amt) | (ring >> rcl_back);

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign dbg_state    = state;

    // Single-cycle result/flag decode; also flags which opcodes start an iteration.
    always_comb begin
        sc_out    = '0;
        sc_hi     = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        arith     = '0;
        start_mul = 1'b0;
        start_div = 1'b0;
        case (bus.alu_control)
            OPC_ADD, OPC_ADC: begin
                arith  = {1'b0, bus.op_a} + {1'b0, bus.op_b}
                       + {{WIDTH{1'b0}}, (bus.alu_control == OPC_ADC) & cin};
                sc_out = arith[WIDTH-1:0];
                sc_c   = arith[WIDTH];
                sc_v   = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1])
                       && (arith[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OPC_SUB, OPC_SBB, OPC_CMP: begin
                // b is effectively inverted, so the overflow rule compares unlike signs.
                arith  = {1'b0, bus.op_a} - {1'b0, bus.op_b}
                       - {{WIDTH{1'b0}}, (bus.alu_control == OPC_SBB) & cin};
                sc_out = arith[WIDTH-1:0];
                sc_c   = arith[WIDTH];
                sc_v   = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1])
                       && (arith[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OPC_AND: sc_out = bus.op_a & bus.op_b;
            OPC_OR:  sc_out = bus.op_a | bus.op_b;
            OPC_XOR: sc_out = bus.op_a ^ bus.op_b;
            OPC_NOT: sc_out = ~bus.op_a;
            // Stores, jumps and pushes forward the address/data operand like MOV.
            OPC_MOV, OPC_ST, OPC_JMP, OPC_PUSH: sc_out = bus.op_b;
            OPC_SHL: begin
                if (amt == '0) begin
                    sc_out = bus.op_a;
                    sc_c   = cin;
                end else begin
                    {sc_c, sc_out} = {1'b0, bus.op_a} << amt;
                end
            end
            OPC_SHR: begin
                sc_out = bus.op_a >> amt;
                sc_c   = (amt == '0) ? cin : 1'b0;
            end
            OPC_ROL: begin
                sc_out = (bus.op_a << amt) | (bus.op_a >> rol_back);
                sc_c   = (amt == '0) ? cin : sc_out[0];
            end
            OPC_RCL: begin
                // Amount 0 leaves the ring untouched, giving out=op_a and C=carry in.
                sc_out = ring_rot[WIDTH-1:0];
                sc_c   = ring_rot[WIDTH];
            end
`ifdef ALU_MULDIV_EN
            OPC_MUL: start_mul = 1'b1;
            OPC_DIV, OPC_MOD: begin
                if (bus.op_b == '0) begin
                    // Divide by zero answers immediately: quotient all ones, remainder op_a.
                    sc_v = 1'b1;
                    if (bus.alu_control == OPC_DIV) begin
                        sc_out = '1;
                        sc_hi  = bus.op_a;
                    end else begin
                        sc_out = bus.op_a;
                        sc_hi  = '1;
                    end
                end else begin
                    start_div = 1'b1;
                end
            end
`endif
            default: sc_out = '0;
        endcase
    end

    // Flag vector and write-enable for single-cycle results.
    always_comb begin
        sc_flags             = '0;
        sc_flags[FLAG_BIT_C] = sc_c;
        sc_flags[FLAG_BIT_Z] = (sc_out == '0);
        sc_flags[FLAG_BIT_S] = sc_out[WIDTH-1];
        sc_flags[FLAG_BIT_V] = sc_v;
        sc_wr                = !((bus.alu_control == OPC_CMP) || (bus.alu_control == OPC_ST)
                               || (bus.alu_control == OPC_JMP) || (bus.alu_control == OPC_PUSH));
    end

`ifdef ALU_MULDIV_EN
    state_e           state_d;
    logic [WIDTH-1:0] a_r;      // multiplier high half / divider partial remainder
    logic [WIDTH-1:0] b_r;      // multiplier low half / dividend shifting into quotient
    logic [WIDTH-1:0] m_r;      // multiplicand / divisor
    logic [CNT_W-1:0] cnt;
    logic             is_mod;
    logic             finish;
    logic [WIDTH-1:0] a_n;
    logic [WIDTH-1:0] b_n;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] md_out;
    logic [WIDTH-1:0] md_hi;
    logic [3:0]       md_flags;

    assign finish = ((state == MUL) || (state == DIV)) && (cnt == CNT_W'(1));

    // Next state: iterate WIDTH cycles, then one DONE cycle while out_valid is shown.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept && start_mul) state_d = MUL;
                else if (accept && start_div) state_d = DIV;
            end
            MUL, DIV: if (cnt == CNT_W'(1)) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // One multiplier or divider step from the current iteration registers.
    always_comb begin
        mul_sum   = {1'b0, a_r} + (b_r[0] ? {1'b0, m_r} : {(WIDTH + 1){1'b0}});
        div_shift = {a_r, b_r[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, m_r});
        div_diff  = div_shift[WIDTH-1:0] - m_r;
        if (state == MUL) begin
            a_n = mul_sum[WIDTH:1];
            b_n = {mul_sum[0], b_r[WIDTH-1:1]};
        end else begin
            a_n = div_ge ? div_diff : div_shift[WIDTH-1:0];
            b_n = {b_r[WIDTH-2:0], div_ge};
        end
    end

    // Final multi-cycle result, taken from the last step so it registers on that edge.
    always_comb begin
        md_out   = b_n;
        md_hi    = a_n;
        md_flags = '0;
        if (state == MUL) begin
            md_flags[FLAG_BIT_C] = (a_n != '0);
            md_flags[FLAG_BIT_V] = (a_n != '0);
        end else if (is_mod) begin
            md_out = a_n;
            md_hi  = b_n;
        end
        md_flags[FLAG_BIT_Z] = (md_out == '0);
        md_flags[FLAG_BIT_S] = md_out[WIDTH-1];
    end

    // Iteration registers: load operands on accept, step while MUL/DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= '0;
            cnt    <= '0;
            is_mod <= 1'b0;
        end else if (accept && start_multi) begin
            a_r    <= '0;
            b_r    <= bus.op_a;
            m_r    <= bus.op_b;
            cnt    <= CNT_W'(WIDTH);
            is_mod <= (bus.alu_control == OPC_MOD);
        end else if ((state == MUL) || (state == DIV)) begin
            a_r <= a_n;
            b_r <= b_n;
            cnt <= cnt - CNT_W'(1);
        end
    end
`else
    assign state = IDLE;
`endif

    // Result registers: load on a single-cycle accept or at the end of an iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_hi    <= '0;
            bus.flags_out <= '0;
            bus.write     <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (accept && !start_multi) begin
                bus.out_valid <= 1'b1;
                bus.out       <= sc_out;
                bus.out_hi    <= sc_hi;
                bus.flags_out <= sc_flags;
                bus.write     <= sc_wr;
            end
`ifdef ALU_MULDIV_EN
            else if (finish) begin
                bus.out_valid <= 1'b1;
                bus.out       <= md_out;
                bus.out_hi    <= md_hi;
                bus.flags_out <= md_flags;
                bus.write     <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a behavioural model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W     = 16;
    localparam int EXP_W = 2 * W + 5;   // {write, flags, out_hi, out}

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W), .SHAMT_W(4), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EXP_W-1:0] exp_q[$];
    int               exp_lat_q[$];

    logic [W-1:0] obs_out;
    logic [W-1:0] obs_hi;
    logic [3:0]   obs_flags;
    logic         obs_wr;
    int           obs_lat;
    int           obs_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode's definition.
    function automatic void model(input logic [7:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] fin, output logic [EXP_W-1:0] e, output int lat);
        longint unsigned ua, ub, mask, r, hi, x, p;
        longint sa, sb, sr, smax, smin;
        bit c, v, wr, cin, cc, nc;
        int amt;
        logic [3:0] fl;
        ua = a; ub = b; mask = (64'd1 << W) - 1;
        r = 0; hi = 0; c = 0; v = 0; lat = 1;
        cin = fin[FLAG_BIT_C];
        sa = longint'(a); if (a[W-1]) sa -= (longint'(1) << W);
        sb = longint'(b); if (b[W-1]) sb -= (longint'(1) << W);
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        amt = int'(ub % W);
        wr = !(opc == OPC_CMP || opc == OPC_ST || opc == OPC_JMP || opc == OPC_PUSH);
        case (opc)
            OPC_ADD, OPC_ADC: begin
                cc = (opc == OPC_ADC) ? cin : 1'b0;
                r  = ua + ub + cc;
                c  = (r > mask);
                sr = sa + sb + cc;
                v  = (sr > smax) || (sr < smin);
            end
            OPC_SUB, OPC_SBB, OPC_CMP: begin
                cc = (opc == OPC_SBB) ? cin : 1'b0;
                r  = ua - ub - cc;
                c  = (ua < ub + cc);
                sr = sa - sb - cc;
                v  = (sr > smax) || (sr < smin);
            end
            OPC_AND: r = ua & ub;
            OPC_OR:  r = ua | ub;
            OPC_XOR: r = ua ^ ub;
            OPC_NOT: r = ~ua;
            OPC_MOV, OPC_ST, OPC_JMP, OPC_PUSH: r = ub;
            OPC_SHL: begin
                if (amt == 0) begin r = ua; c = cin; end
                else begin r = ua << amt; c = (ua >> (W - amt)) & 1; end
            end
            OPC_SHR: begin
                r = ua >> amt;
                c = (amt == 0) ? cin : 1'b0;
            end
            OPC_ROL: begin
                x = ua;
                repeat (amt) x = ((x << 1) | (x >> (W - 1))) & mask;
                r = x;
                c = (amt == 0) ? cin : x[0];
            end
            OPC_RCL: begin
                x = ua; cc = cin;
                repeat (amt) begin
                    nc = x[W-1];
                    x  = ((x << 1) | cc) & mask;
                    cc = nc;
                end
                r = x; c = cc;
            end
`ifdef ALU_MULDIV_EN
            OPC_MUL: begin
                p   = ua * ub;
                r   = p & mask;
                hi  = p >> W;
                c   = (hi != 0);
                v   = (hi != 0);
                lat = W + 1;
            end
            OPC_DIV, OPC_MOD: begin
                longint unsigned q, rm;
                if (ub == 0) begin
                    q = mask; rm = ua; v = 1;
                end else begin
                    q = ua / ub; rm = ua % ub; lat = W + 1;
                end
                if (opc == OPC_DIV) begin r = q; hi = rm; end
                else begin r = rm; hi = q; end
            end
`endif
            default: r = 0;
        endcase
        r = r & mask;
        fl = '0;
        fl[FLAG_BIT_C] = c;
        fl[FLAG_BIT_Z] = (r == 0);
        fl[FLAG_BIT_S] = r[W-1];
        fl[FLAG_BIT_V] = v;
        e = {wr, fl, hi[W-1:0], r[W-1:0]};
    endfunction

    // Driver: issue one request, wait for out_valid, compare against the scoreboard.
    // With poke set, a second request is presented while the ALU is busy.
    task automatic run_op(input logic [7:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] fin, input bit poke);
        logic [EXP_W-1:0] e;
        int el;
        bit got;
        model(opc, a, b, fin, e, el);
        exp_q.push_back(e);
        exp_lat_q.push_back(el);
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid    = 1'b1;
        bus.alu_control = opc;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.flags_in    = fin;
        obs_lat = 0; obs_busy = 0; got = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            obs_lat++;
            if (obs_lat == 1) bus.in_valid = 1'b0;
            if (poke && obs_lat >= 3 && obs_lat <= 6) begin
                check("in_ready_busy", bus.in_ready, 0);
                bus.in_valid    = 1'b1;
                bus.alu_control = OPC_ADD;
                bus.op_a        = 16'h0001;
                bus.op_b        = 16'h0001;
            end
            if (poke && obs_lat == 7) bus.in_valid = 1'b0;
            if (bus.busy) obs_busy++;
            if (bus.out_valid) begin got = 1; break; end
        end
        if (!got) check("out_valid_timeout", bus.out_valid, 1);
        obs_out = bus.out; obs_hi = bus.out_hi; obs_flags = bus.flags_out; obs_wr = bus.write;
        e  = exp_q.pop_front();
        el = exp_lat_q.pop_front();
        check("out",     obs_out,   e[W-1:0]);
        check("out_hi",  obs_hi,    e[2*W-1:W]);
        check("flags",   obs_flags, e[2*W+3:2*W]);
        check("write",   obs_wr,    e[2*W+4]);
        check("latency", obs_lat,   el);
        check("busy_cycles", obs_busy, (el > 1) ? el : 0);
        @(posedge clk); #1;
        check("out_valid_pulse", bus.out_valid, 0);
        check("out_hold", bus.out, obs_out);
    endtask

    initial begin
        int ov_seen;
        logic [7:0] opc;
        logic [W-1:0] ra, rb;
        bus.in_valid = 1'b0; bus.alu_control = '0; bus.op_a = '0; bus.op_b = '0; bus.flags_in = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", bus.out, 0);
        check("rst_out_hi", bus.out_hi, 0);
        check("rst_flags", bus.flags_out, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_write", bus.write, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // ADD signed overflow: V=1, S=1.
        run_op(OPC_ADD, 16'h7FFF, 16'h0001, 4'h0, 0);
        check("add_out", obs_out, 16'h8000);
        check("add_flags", obs_flags, 4'b1100);
        // SUB borrow, then CMP with no writeback.
        run_op(OPC_SUB, 16'h0000, 16'h0001, 4'h0, 0);
        check("sub_out", obs_out, 16'hFFFF);
        check("sub_flags", obs_flags, 4'b0101);
        check("sub_write", obs_wr, 1);
        run_op(OPC_CMP, 16'h0000, 16'h0001, 4'h0, 0);
        check("cmp_write", obs_wr, 0);
        check("cmp_flags", obs_flags, 4'b0101);
        // Rotates.
        run_op(OPC_RCL, 16'h8001, 16'h0001, 4'h0, 0);
        check("rcl_out", obs_out, 16'h0002);
        check("rcl_c", obs_flags[FLAG_BIT_C], 1);
        run_op(OPC_ROL, 16'h8001, 16'h0001, 4'h0, 0);
        check("rol_out", obs_out, 16'h0003);
        check("rol_c", obs_flags[FLAG_BIT_C], 1);
        // Shift by zero keeps op_a and carry in.
        run_op(OPC_SHL, 16'h1234, 16'h0010, 4'h1, 0);
        check("shl0_out", obs_out, 16'h1234);
        // Unknown opcode.
        run_op(8'hFF, 16'h1234, 16'h5678, 4'hF, 0);
        check("unk_flags", obs_flags, 4'b0010);
`ifdef ALU_MULDIV_EN
        run_op(OPC_MUL, 16'hFFFF, 16'hFFFF, 4'h0, 1);
        check("mul_out", obs_out, 16'h0001);
        check("mul_hi", obs_hi, 16'hFFFE);
        check("mul_flags", obs_flags, 4'b1001);
        check("mul_latency", obs_lat, 17);
        run_op(OPC_DIV, 16'd100, 16'd7, 4'h0, 0);
        check("div_out", obs_out, 16'd14);
        check("div_hi", obs_hi, 16'd2);
        run_op(OPC_DIV, 16'd100, 16'd0, 4'h0, 0);
        check("div0_out", obs_out, 16'hFFFF);
        check("div0_hi", obs_hi, 16'd100);
        check("div0_v", obs_flags[FLAG_BIT_V], 1);
        check("div0_latency", obs_lat, 1);
        run_op(OPC_MOD, 16'd100, 16'd7, 4'h0, 0);
        check("mod_out", obs_out, 16'd2);
`else
        run_op(OPC_MUL, 16'hFFFF, 16'hFFFF, 4'h0, 0);
        check("mul_unk_out", obs_out, 0);
        check("mul_unk_flags", obs_flags, 4'b0010);
        run_op(OPC_DIV, 16'd100, 16'd7, 4'h0, 0);
        check("div_unk_latency", obs_lat, 1);
`endif

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_control = OPC_MUL; bus.op_a = 16'd3; bus.op_b = 16'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out", bus.out, 0);
        check("midrst_out_hi", bus.out_hi, 0);
        check("midrst_flags", bus.flags_out, 0);
        check("midrst_write", bus.write, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_seen++;
        end
        check("midrst_no_out_valid", ov_seen, 0);
        run_op(OPC_ADD, 16'd1, 16'd1, 4'h0, 0);
        check("post_rst_add", obs_out, 16'd2);

        // Randomized operations, including unknown opcodes and zero divisors.
        for (int n = 0; n < 80; n++) begin
            opc = 8'($urandom_range(0, 23));
            if ($urandom_range(0, 15) == 0) opc = 8'($urandom_range(24, 255));
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 5) == 0) rb = '0;
            if ($urandom_range(0, 5) == 0) rb = W'($urandom_range(1, 20));
            run_op(opc, ra, rb, 4'($urandom_range(0, 15)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
